occ_gtp_rx_pattern_checker: RTL and testbench

OCC_GTP_RX_PATTERN_CHECKER -- requirements
Module: occ_gtp_rx_pattern_checker

---
 rtl/occ_gtp_rx_pattern_checker.sv | 144 ++++++++++++++
 tb/tb_occ_gtp_rx_pattern_checker.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_gtp_rx_pattern_checker.sv
// rtl/occ_gtp_rx_pattern_checker.sv - GTP receive counter-pattern checker with lock FSM and saturating counters
`timescale 1ns/1ps
module occ_gtp_rx_pattern_checker #(
    parameter int g_LOSS_THRESHOLD = 4,
    parameter int g_CNT_WIDTH      = 32
) (
    input  logic                   usrclk_i,
    input  logic                   rst_n_i,
    input  logic [15:0]            rxdata_i,
    input  logic [1:0]             rxcharisk_i,
    input  logic [1:0]             rxdisperr_i,
    input  logic [1:0]             rxnotintable_i,
    input  logic                   rxresetdone_i,
    input  logic                   clr_i,
    output logic                   locked_o,
    output logic                   err_o,
    output logic [g_CNT_WIDTH-1:0] word_cnt_o,
    output logic [g_CNT_WIDTH-1:0] err_cnt_o
);
    localparam logic [15:0]            c_COMMA_DATA = 16'hBC95;
    localparam logic [1:0]             c_COMMA_K    = 2'b10;
    localparam logic [3:0]             c_THRESH     = 4'(g_LOSS_THRESHOLD);
    localparam logic [g_CNT_WIDTH-1:0] c_CNT_ONE    = {{(g_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [15:0]            r_exp;
    logic [15:0]            w_next_exp;
    logic [3:0]             r_bad_run;
    logic [3:0]             w_next_bad_run;
    logic                   r_locked;
    logic                   r_err;
    logic [g_CNT_WIDTH-1:0] r_word_cnt;
    logic [g_CNT_WIDTH-1:0] r_err_cnt;

    logic w_flags_clean;
    logic w_is_comma;
    logic w_exp_comma;
    logic w_match;
    logic w_bad;
    logic w_eval;
    logic w_err_next;

    // Word classification against the expected counter value C (r_exp)
    assign w_flags_clean = (rxdisperr_i == 2'b00) && (rxnotintable_i == 2'b00);
    assign w_is_comma    = (rxdata_i == c_COMMA_DATA) && (rxcharisk_i == c_COMMA_K);
    assign w_exp_comma   = (r_exp[4:0] == 5'd0);
    assign w_match       = w_exp_comma ? w_is_comma
                                       : ((rxcharisk_i == 2'b00) && (rxdata_i == r_exp));
    assign w_bad         = !w_match || !w_flags_clean;
    assign w_eval        = rxresetdone_i && (r_state == ST_LOCKED);
    assign w_err_next    = w_eval && w_bad;

    // Next-state logic: hunt for comma, confirm with the following data word, then track
    always_comb begin
        w_next_state   = r_state;
        w_next_exp     = r_exp;
        w_next_bad_run = r_bad_run;
        if (!rxresetdone_i) begin
            w_next_state   = ST_SEARCH;
            w_next_bad_run = 4'd0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    if (w_is_comma && w_flags_clean) begin
                        w_next_state = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if ((rxcharisk_i == 2'b00) && (rxdata_i[4:0] == 5'd1) && w_flags_clean) begin
                        w_next_state   = ST_LOCKED;
                        w_next_exp     = rxdata_i + 16'd1;
                        w_next_bad_run = 4'd0;
                    end else begin
                        w_next_state = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    w_next_exp = r_exp + 16'd1;
                    if (w_bad) begin
                        if ((r_bad_run + 4'd1) >= c_THRESH) begin
                            w_next_state   = ST_SEARCH;
                            w_next_bad_run = 4'd0;
                        end else begin
                            w_next_bad_run = r_bad_run + 4'd1;
                        end
                    end else begin
                        w_next_bad_run = 4'd0;
                    end
                end
                default: begin
                    w_next_state   = ST_SEARCH;
                    w_next_bad_run = 4'd0;
                end
            endcase
        end
    end

    // State, expected counter, bad-run count and registered status outputs
    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_SEARCH;
            r_exp     <= 16'd0;
            r_bad_run <= 4'd0;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_exp     <= w_next_exp;
            r_bad_run <= w_next_bad_run;
            r_locked  <= (w_next_state == ST_LOCKED);
            r_err     <= w_err_next;
        end
    end

    // Saturating word/error counters; clear wins over a same-cycle increment
    always_ff @(posedge usrclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (clr_i) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_eval && (r_word_cnt != '1)) begin
                r_word_cnt <= r_word_cnt + c_CNT_ONE;
            end
            if (w_err_next && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign locked_o   = r_locked;
    assign err_o      = r_err;
    assign word_cnt_o = r_word_cnt;
    assign err_cnt_o  = r_err_cnt;
endmodule

// File: tb/tb_occ_gtp_rx_pattern_checker.sv
// tb/tb_occ_gtp_rx_pattern_checker.sv - randomized self-checking bench with a behavioural stream model
`timescale 1ns/1ps
module tb_occ_gtp_rx_pattern_checker;
    localparam int THR = 4;

    logic        usrclk_i;
    logic        rst_n_i;
    logic [15:0] rxdata_i;
    logic [1:0]  rxcharisk_i;
    logic [1:0]  rxdisperr_i;
    logic [1:0]  rxnotintable_i;
    logic        rxresetdone_i;
    logic        clr_i;
    logic        locked_o;
    logic        err_o;
    logic [31:0] word_cnt_o;
    logic [31:0] err_cnt_o;
    logic        n_locked;
    logic        n_err;
    logic [3:0]  n_word_cnt;
    logic [3:0]  n_err_cnt;

    occ_gtp_rx_pattern_checker #(.g_LOSS_THRESHOLD(THR), .g_CNT_WIDTH(32)) u_dut (
        .usrclk_i(usrclk_i), .rst_n_i(rst_n_i), .rxdata_i(rxdata_i), .rxcharisk_i(rxcharisk_i),
        .rxdisperr_i(rxdisperr_i), .rxnotintable_i(rxnotintable_i), .rxresetdone_i(rxresetdone_i),
        .clr_i(clr_i), .locked_o(locked_o), .err_o(err_o), .word_cnt_o(word_cnt_o), .err_cnt_o(err_cnt_o)
    );

    occ_gtp_rx_pattern_checker #(.g_LOSS_THRESHOLD(THR), .g_CNT_WIDTH(4)) u_dut_narrow (
        .usrclk_i(usrclk_i), .rst_n_i(rst_n_i), .rxdata_i(rxdata_i), .rxcharisk_i(rxcharisk_i),
        .rxdisperr_i(rxdisperr_i), .rxnotintable_i(rxnotintable_i), .rxresetdone_i(rxresetdone_i),
        .clr_i(clr_i), .locked_o(n_locked), .err_o(n_err), .word_cnt_o(n_word_cnt), .err_cnt_o(n_err_cnt)
    );

    initial usrclk_i = 1'b0;
    always #5 usrclk_i = ~usrclk_i;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     g_c     = 0;

    // Behavioural reference: is the stream being tracked, was a comma just seen, what C comes next
    bit     m_tracking;
    bit     m_comma_seen;
    bit     m_err;
    int     m_next;
    int     m_run;
    longint m_words;
    longint m_errs;

    function automatic logic [3:0] sat4(input longint v);
        return (v > 15) ? 4'hF : v[3:0];
    endfunction

    task automatic model_reset();
        m_tracking = 0; m_comma_seen = 0; m_err = 0;
        m_next = 0; m_run = 0; m_words = 0; m_errs = 0;
    endtask

    task automatic model_step(input logic [15:0] data, input logic [1:0] k, input logic [1:0] de,
                              input logic [1:0] nt, input logic rd, input logic cl);
        bit clean;
        bit comma;
        bit good;
        clean = (de == 2'b00) && (nt == 2'b00);
        comma = (data == 16'hBC95) && (k == 2'b10);
        m_err = 0;
        if (!rd) begin
            m_tracking = 0; m_comma_seen = 0; m_run = 0;
        end else if (m_tracking) begin
            if (m_next % 32 == 0) good = comma && clean;
            else                  good = (k == 2'b00) && (data == 16'(m_next)) && clean;
            m_words++;
            if (good) m_run = 0;
            else begin m_err = 1; m_errs++; m_run++; end
            m_next = (m_next + 1) % 65536;
            if (m_run == THR) begin m_tracking = 0; m_run = 0; end
        end else if (m_comma_seen) begin
            m_comma_seen = 0;
            if ((k == 2'b00) && (data[4:0] == 5'd1) && clean) begin
                m_tracking = 1; m_next = (int'(data) + 1) % 65536; m_run = 0;
            end
        end else begin
            m_comma_seen = comma && clean;
        end
        if (cl) begin m_words = 0; m_errs = 0; end
    endtask

    task automatic gen_word(input int c, output logic [15:0] d, output logic [1:0] k);
        if (c % 32 == 0) begin d = 16'hBC95; k = 2'b10; end
        else begin d = c[15:0]; k = 2'b00; end
    endtask

    task automatic drive(input logic [15:0] data, input logic [1:0] k, input logic [1:0] de,
                         input logic [1:0] nt, input logic rd, input logic cl);
        rxdata_i = data; rxcharisk_i = k; rxdisperr_i = de; rxnotintable_i = nt;
        rxresetdone_i = rd; clr_i = cl;
        @(posedge usrclk_i);
        model_step(data, k, de, nt, rd, cl);
        #1;
    endtask

    task automatic good_word();
        logic [15:0] d;
        logic [1:0]  k;
        gen_word(g_c, d, k);
        drive(d, k, 2'b00, 2'b00, 1'b1, 1'b0);
        g_c = (g_c + 1) % 65536;
    endtask

    task automatic lock_at(input int c0);
        drive(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        g_c = c0;
        repeat (3) good_word();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b1; rxresetdone_i = 1'b0; clr_i = 1'b0; rxdata_i = '0;
        rxcharisk_i = '0; rxdisperr_i = '0; rxnotintable_i = '0;
        #1 rst_n_i = 1'b0;
        model_reset();
        #1;
        n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        n_tests++; if (word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_word_cnt got %0d want 0", word_cnt_o); end
        n_tests++; if (err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt_o); end
        repeat (3) @(posedge usrclk_i);
        #1 rst_n_i = 1'b1;
        n_tests++;
        if ({n_locked, n_err, n_word_cnt, n_err_cnt} !== 10'd0) begin
            n_fail++; $display("FAIL reset_narrow got %b want 0", {n_locked, n_err, n_word_cnt, n_err_cnt});
        end
    endtask

    task automatic test_clean_lock();
        int pulses = 0;
        g_c = 32;
        for (int i = 0; i < 40; i++) begin
            good_word();
            if (err_o) pulses++;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL clean_lock i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
            if (i == 0) begin n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL clean_lock_early got %b want 0", locked_o); end end
            if (i == 2) begin n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL clean_lock_locked got %b want 1", locked_o); end end
        end
        n_tests++; if (word_cnt_o !== 32'd38) begin n_fail++; $display("FAIL clean_word_cnt got %0d want 38", word_cnt_o); end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL clean_err_pulses got %0d want 0", pulses); end
    endtask

    task automatic test_single_corruption();
        int pulses = 0;
        logic [15:0] d;
        logic [1:0]  k;
        lock_at(32'h40);
        gen_word(g_c, d, k); drive(d, k, 2'b00, 2'b00, 1'b1, 1'b1); g_c++;
        for (int i = 0; i < 20; i++) begin
            gen_word(g_c, d, k);
            if (g_c == 32'h45) d = 16'h0046;
            drive(d, k, 2'b00, 2'b00, 1'b1, 1'b0);
            g_c = (g_c + 1) % 65536;
            if (err_o) pulses++;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL single_corrupt i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
            n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL single_corrupt_locked i=%0d got %b want 1", i, locked_o); end
        end
        n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL single_corrupt_pulses got %0d want 1", pulses); end
        n_tests++; if (err_cnt_o !== 32'd1) begin n_fail++; $display("FAIL single_corrupt_err_cnt got %0d want 1", err_cnt_o); end
    endtask

    task automatic test_loss_of_lock();
        int pulses = 0;
        logic [15:0] d;
        logic [1:0]  k;
        for (int i = 0; i < 4; i++) begin
            gen_word(g_c, d, k);
            d = d ^ (16'h1 << $urandom_range(15, 0));
            drive(d, k, 2'b00, 2'b00, 1'b1, 1'b0);
            g_c = (g_c + 1) % 65536;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL loss_model i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
            n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL loss_err_pulse i=%0d got %b want 1", i, err_o); end
            if (i < 3) begin n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL loss_early_drop i=%0d got %b want 1", i, locked_o); end end
        end
        n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL loss_dropped got %b want 0", locked_o); end
        for (int i = 0; i < 80; i++) begin
            good_word();
            if (err_o) pulses++;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL relock_model i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL relock_pulses got %0d want 0", pulses); end
        n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL relock_locked got %b want 1", locked_o); end
    endtask

    task automatic test_wrap();
        int pulses = 0;
        lock_at(32'hFFE0);
        for (int i = 0; i < 40; i++) begin
            good_word();
            if (err_o) pulses++;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL wrap_model i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL wrap_pulses got %0d want 0", pulses); end
        n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL wrap_locked got %b want 1", locked_o); end
    endtask

    task automatic test_code_errors();
        logic [15:0] d;
        logic [1:0]  k;
        longint      w_save;
        longint      e_save;
        bit          got = 0;
        gen_word(g_c, d, k); drive(d, k, 2'b01, 2'b00, 1'b1, 1'b0); g_c = (g_c + 1) % 65536;
        n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL disperr_pulse got %b want 1", err_o); end
        repeat (3) good_word();
        n_tests++; if ({locked_o, err_o} !== 2'b10) begin n_fail++; $display("FAIL disperr_after got %b want 10", {locked_o, err_o}); end
        w_save = m_words; e_save = m_errs;
        gen_word(g_c, d, k); drive(d, k, 2'b00, 2'b00, 1'b0, 1'b0); g_c = (g_c + 1) % 65536;
        n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL resetdone_locked got %b want 0", locked_o); end
        n_tests++;
        if (word_cnt_o !== w_save[31:0] || err_cnt_o !== e_save[31:0]) begin
            n_fail++; $display("FAIL resetdone_held got %0d,%0d want %0d,%0d", word_cnt_o, err_cnt_o, w_save, e_save);
        end
        for (int i = 0; i < 80 && !got; i++) begin
            good_word();
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL ctrl_relock i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
            if (locked_o === 1'b1) got = 1;
        end
        n_tests++; if (!got) begin n_fail++; $display("FAIL ctrl_relock_timeout got locked=%b want 1", locked_o); end
        gen_word(g_c, d, k); d = d ^ 16'h0001; drive(d, k, 2'b00, 2'b00, 1'b1, 1'b1); g_c = (g_c + 1) % 65536;
        n_tests++;
        if ({err_o, err_cnt_o} !== {1'b1, 32'd0}) begin
            n_fail++; $display("FAIL clr_with_err got err=%b cnt=%0d want err=1 cnt=0", err_o, err_cnt_o);
        end
        gen_word(g_c, d, k); drive(d, k, 2'b00, 2'b00, 1'b1, 1'b1); g_c = (g_c + 1) % 65536;
        n_tests++; if (err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL clr_during_err got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_bad_sync();
        drive(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        g_c = 32;
        good_word();
        drive(16'h0005, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
        g_c = 34;
        n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL bad_sync_locked got %b want 0", locked_o); end
        for (int i = 0; i < 10; i++) begin
            good_word();
            n_tests++;
            if ({locked_o, err_o} !== 2'b00) begin
                n_fail++; $display("FAIL bad_sync_search i=%0d got %b want 00", i, {locked_o, err_o});
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        logic [1:0]  k;
        lock_at(32'h80);
        gen_word(g_c, d, k); drive(d, k, 2'b00, 2'b00, 1'b1, 1'b1); g_c++;
        for (int i = 0; i < 40; i++) begin
            gen_word(g_c, d, k);
            if (i % 2 == 0) d = d ^ 16'h0100;
            drive(d, k, 2'b00, 2'b00, 1'b1, 1'b0);
            g_c = (g_c + 1) % 65536;
            n_tests++;
            if ({n_locked, n_err, n_word_cnt, n_err_cnt} !== {m_tracking, m_err, sat4(m_words), sat4(m_errs)}) begin
                n_fail++; $display("FAIL sat_narrow i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    n_locked, n_err, n_word_cnt, n_err_cnt, m_tracking, m_err, sat4(m_words), sat4(m_errs));
            end
        end
        n_tests++; if (n_err_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_err_cnt got %0d want 15", n_err_cnt); end
        n_tests++; if (n_word_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_word_cnt got %0d want 15", n_word_cnt); end
        n_tests++; if (err_cnt_o !== 32'd20) begin n_fail++; $display("FAIL sat_wide_err got %0d want 20", err_cnt_o); end
        n_tests++; if (word_cnt_o !== 32'd40) begin n_fail++; $display("FAIL sat_wide_word got %0d want 40", word_cnt_o); end
        n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL sat_locked got %b want 1", locked_o); end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [1:0]  k;
        logic [1:0]  de;
        logic [1:0]  nt;
        logic        rd;
        logic        cl;
        int          r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(99, 0);
            if (r < 2) g_c = $urandom_range(65535, 0);
            gen_word(g_c, d, k);
            de = 2'b00; nt = 2'b00; rd = 1'b1;
            if (r >= 2 && r < 6) rd = 1'b0;
            else if (r >= 6 && r < 14) d = d ^ (16'h1 << $urandom_range(15, 0));
            else if (r >= 14 && r < 18) begin de = 2'($urandom_range(3, 1)); nt = 2'($urandom_range(3, 0)); end
            else if (r >= 18 && r < 20) k = k ^ 2'b01;
            cl = ($urandom_range(99, 0) < 3);
            drive(d, k, de, nt, rd, cl);
            g_c = (g_c + 1) % 65536;
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL random_wide i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
            n_tests++;
            if ({n_locked, n_err, n_word_cnt, n_err_cnt} !== {m_tracking, m_err, sat4(m_words), sat4(m_errs)}) begin
                n_fail++; $display("FAIL random_narrow i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    n_locked, n_err, n_word_cnt, n_err_cnt, m_tracking, m_err, sat4(m_words), sat4(m_errs));
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        logic [15:0] d;
        logic [1:0]  k;
        lock_at(32'h20);
        repeat (2) good_word();
        gen_word(g_c, d, k); d = d ^ 16'h0004; drive(d, k, 2'b00, 2'b00, 1'b1, 1'b0); g_c = (g_c + 1) % 65536;
        n_tests++; if ({locked_o, err_o} !== 2'b11) begin n_fail++; $display("FAIL pre_reset got %b want 11", {locked_o, err_o}); end
        #2 rst_n_i = 1'b0;
        #1;
        model_reset();
        n_tests++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_locked got %b want 0", locked_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL async_reset_err got %b want 0", err_o); end
        n_tests++;
        if (word_cnt_o !== 32'd0 || err_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL async_reset_cnt got %0d,%0d want 0,0", word_cnt_o, err_cnt_o);
        end
        @(posedge usrclk_i);
        #1 rst_n_i = 1'b1;
        g_c = 32'h40;
        for (int i = 0; i < 6; i++) begin
            good_word();
            n_tests++;
            if ({locked_o, err_o, word_cnt_o, err_cnt_o} !== {m_tracking, m_err, m_words[31:0], m_errs[31:0]}) begin
                n_fail++; $display("FAIL post_reset i=%0d got %b,%b,%0d,%0d want %b,%b,%0d,%0d", i,
                    locked_o, err_o, word_cnt_o, err_cnt_o, m_tracking, m_err, m_words, m_errs);
            end
        end
        n_tests++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_locked got %b want 1", locked_o); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_corruption();
        test_loss_of_lock();
        test_wrap();
        test_code_errors();
        test_bad_sync();
        test_saturation();
        test_random();
        test_reset_mid_lock();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
